shreg_piso_tx: RTL and testbench

//  Parallel-in/serial-out transmitter for the 4-bit shift-register datapath.

---
 rtl/shreg_piso_tx_if.sv | 24 ++
 rtl/shreg_piso_tx.sv | 156 +++++++++++++++
 tb/tb_shreg_piso_tx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shreg_piso_tx_if.sv
// Word-load handshake and serial output bundle of the PISO transmitter.
// master: the word source; slave: the transmitter itself.
interface shreg_piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] DIN;
  logic             LOAD_VALID;
  logic             LOAD_READY;
  logic             SOUT;
  logic             SVALID;
  logic             SFRAME;
  logic             BUSY;
  logic             DONE;

  modport master (
    output DIN, LOAD_VALID,
    input  LOAD_READY, SOUT, SVALID, SFRAME, BUSY, DONE
  );

  modport slave (
    input  DIN, LOAD_VALID,
    output LOAD_READY, SOUT, SVALID, SFRAME, BUSY, DONE
  );
endinterface

// File: rtl/shreg_piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on a
// valid/ready handshake and shifts it out one bit per enabled clock,
// framed by SVALID/SFRAME/DONE strobes and an optional idle gap.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | waiting for a word; LOAD_READY=1
//  S_SHIFT | a data bit is on SOUT; cnt_q = bits still to follow it
//  S_GAP   | frame finished, inserting GAP idle cycles with BUSY=1
module shreg_piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              EN,
  shreg_piso_tx_if.slave    bus
);

  localparam int CW = $clog2(WIDTH);
  // gap counter only needs to hold GAP-1
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             sout_q, sout_d;
  logic             svalid_q, svalid_d;
  logic             sframe_q, sframe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Bit leaving first from the incoming word / the shift register, and the
  // register contents once that bit has gone. The register always holds the
  // bits not yet presented, aligned at the outgoing end.
  logic             din_first;
  logic             shreg_next_bit;
  logic [WIDTH-1:0] din_rest;
  logic [WIDTH-1:0] shreg_rest;

  assign din_first      = MSB_FIRST ? bus.DIN[WIDTH-1] : bus.DIN[0];
  assign shreg_next_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign din_rest       = MSB_FIRST ? {bus.DIN[WIDTH-2:0], 1'b0}
                                    : {1'b0, bus.DIN[WIDTH-1:1]};
  assign shreg_rest     = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_q[WIDTH-1:1]};

  // State and registered outputs; everything holds while EN is low.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      sout_q   <= 1'b0;
      svalid_q <= 1'b0;
      sframe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (EN) begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      sout_q   <= sout_d;
      svalid_q <= svalid_d;
      sframe_q <= sframe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic; strobes default low each enabled edge.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    sout_d   = sout_q;
    svalid_d = svalid_q;
    sframe_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        sout_d   = 1'b0;
        svalid_d = 1'b0;
        busy_d   = 1'b0;
        if (bus.LOAD_VALID) begin
          state_d  = S_SHIFT;
          shreg_d  = din_rest;
          cnt_d    = CNT_LAST;
          sout_d   = din_first;
          svalid_d = 1'b1;
          sframe_d = 1'b1;
          busy_d   = 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_q == '0) begin
          sout_d   = 1'b0;
          svalid_d = 1'b0;
          done_d   = 1'b1;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          sout_d  = shreg_next_bit;
          shreg_d = shreg_rest;
          cnt_d   = cnt_q - CW'(1);
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: begin
        state_d  = S_IDLE;
        sout_d   = 1'b0;
        svalid_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign bus.LOAD_READY = (state_q == S_IDLE);
  assign bus.SOUT       = sout_q;
  assign bus.SVALID     = svalid_q;
  assign bus.SFRAME     = sframe_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;

endmodule

// File: tb/tb_shreg_piso_tx.sv
// Bench for shreg_piso_tx: three instances (MSB-first/no gap, LSB-first/no
// gap, MSB-first/GAP=2) share CLK, CLR, EN and the word source. Each is
// compared every cycle against a frame-position model; directed tables and
// sequences pin down the specific scenarios.
module tb_shreg_piso_tx;

  localparam int W = 4;

  logic       CLK;
  logic       CLR;
  logic       en;
  logic       lv;
  logic [3:0] din;

  int n_err    = 0;
  int n_checks = 0;
  int cyc      = 0;

  shreg_piso_tx_if #(.WIDTH(W)) if0 ();
  shreg_piso_tx_if #(.WIDTH(W)) if1 ();
  shreg_piso_tx_if #(.WIDTH(W)) if2 ();

  assign if0.DIN = din;  assign if0.LOAD_VALID = lv;
  assign if1.DIN = din;  assign if1.LOAD_VALID = lv;
  assign if2.DIN = din;  assign if2.LOAD_VALID = lv;

  shreg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(0)) u0 (
    .CLK(CLK), .CLR(CLR), .EN(en), .bus(if0));
  shreg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(0)) u1 (
    .CLK(CLK), .CLR(CLR), .EN(en), .bus(if1));
  shreg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(2)) u2 (
    .CLK(CLK), .CLR(CLR), .EN(en), .bus(if2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: each instance is described only by where it is in its
  // frame. pos 0 = idle, 1..W = data bit pos-1 on the line, W+1 = DONE cycle,
  // up to W+GAP = gap cycles, W+GAP+1 = finished and ready again.
  int         pos  [3];
  logic [3:0] word [3];
  int         gapp [3] = '{0, 0, 2};
  bit         msbp [3] = '{1'b1, 1'b0, 1'b1};

  function automatic bit model_ready(input int i);
    return (pos[i] == 0) || (pos[i] >= W + gapp[i] + 1);
  endfunction

  // Output vector order: {LOAD_READY, SOUT, SVALID, SFRAME, BUSY, DONE}
  function automatic logic [5:0] model_out(input int i);
    logic r, so, sv, sf, b, d;
    int   p;
    p  = pos[i];
    r  = model_ready(i);
    so = 1'b0; sv = 1'b0; sf = 1'b0; b = 1'b0; d = 1'b0;
    if (p >= 1 && p <= W) begin
      so = msbp[i] ? word[i][W-p] : word[i][p-1];
      sv = 1'b1;
      sf = (p == 1);
      b  = 1'b1;
    end else if (p == W + 1) begin
      d = 1'b1;
      b = (gapp[i] > 0);
    end else if (p > W + 1 && p <= W + gapp[i]) begin
      b = 1'b1;
    end
    return {r, so, sv, sf, b, d};
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (en) begin
        if (model_ready(i) && lv) begin
          pos[i]  = 1;
          word[i] = din;
        end else if (pos[i] == 0 || pos[i] >= W + gapp[i] + 1) begin
          pos[i] = 0;
        end else begin
          pos[i] = pos[i] + 1;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pos[i]  = 0;
      word[i] = '0;
    end
  endtask

  function automatic logic [5:0] dut_out(input int i);
    case (i)
      0:       return {if0.LOAD_READY, if0.SOUT, if0.SVALID, if0.SFRAME, if0.BUSY, if0.DONE};
      1:       return {if1.LOAD_READY, if1.SOUT, if1.SVALID, if1.SFRAME, if1.BUSY, if1.DONE};
      default: return {if2.LOAD_READY, if2.SOUT, if2.SVALID, if2.SFRAME, if2.BUSY, if2.DONE};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then
  // compare all instances on the falling edge.
  task automatic cycle(input logic e, input logic v, input logic [3:0] d);
    en  = e;
    lv  = v;
    din = d;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    cyc++;
    for (int i = 0; i < 3; i++)
      chk($sformatf("model_u%0d", i), dut_out(i), model_out(i));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 4'h0);
  endtask

  // Short asynchronous clear between edges; outputs must drop at once.
  task automatic clr_pulse();
    CLR = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("clr_async_u%0d", i), dut_out(i), 6'b100000);
    #1;
    CLR = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       en;
    logic       lv;
    logic [3:0] din;
    logic [5:0] exp;
  } vec_t;

  vec_t       tbl [22];
  logic [5:0] t5  [11];
  logic [5:0] t6  [10];
  bit         t2  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit         t4  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    // u0 (MSB first, no gap): 1011 frame, 0110 frame with EN low twice,
    // 1001 frame with SFRAME and DONE stretched by EN low.
    tbl[0]  = '{1'b1, 1'b1, 4'hB, 6'b011110};
    tbl[1]  = '{1'b1, 1'b0, 4'h0, 6'b001010};
    tbl[2]  = '{1'b1, 1'b0, 4'h0, 6'b011010};
    tbl[3]  = '{1'b1, 1'b0, 4'h0, 6'b011010};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 6'b100001};
    tbl[5]  = '{1'b1, 1'b0, 4'h0, 6'b100000};
    tbl[6]  = '{1'b1, 1'b1, 4'h6, 6'b001110};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 6'b011010};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 6'b011010};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 6'b011010};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 6'b011010};
    tbl[11] = '{1'b1, 1'b0, 4'h0, 6'b001010};
    tbl[12] = '{1'b1, 1'b0, 4'h0, 6'b100001};
    tbl[13] = '{1'b1, 1'b0, 4'h0, 6'b100000};
    tbl[14] = '{1'b1, 1'b1, 4'h9, 6'b011110};
    tbl[15] = '{1'b0, 1'b0, 4'h0, 6'b011110};
    tbl[16] = '{1'b1, 1'b0, 4'h0, 6'b001010};
    tbl[17] = '{1'b1, 1'b0, 4'h0, 6'b001010};
    tbl[18] = '{1'b1, 1'b0, 4'h0, 6'b011010};
    tbl[19] = '{1'b1, 1'b0, 4'h0, 6'b100001};
    tbl[20] = '{1'b0, 1'b0, 4'h0, 6'b100001};
    tbl[21] = '{1'b1, 1'b0, 4'h0, 6'b100000};

    // u2 (GAP=2), LOAD_VALID held: A then 5, frames 7 cycles apart
    t5 = '{6'b011110, 6'b001010, 6'b011010, 6'b001010, 6'b000011, 6'b000010,
           6'b100000, 6'b001110, 6'b011010, 6'b001010, 6'b011010};

    // u0: 0101 frame with an F pulse during SHIFT, then nothing more
    t6 = '{6'b001110, 6'b011010, 6'b001010, 6'b011010, 6'b100001,
           6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000};

    CLR = 1'b1;
    en  = 1'b0;
    lv  = 1'b0;
    din = 4'h0;
    model_reset();
    #2;
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_u%0d", i), dut_out(i), 6'b100000);
    @(negedge CLK);
    CLR = 1'b0;

    for (int k = 0; k < 22; k++) begin
      cycle(tbl[k].en, tbl[k].lv, tbl[k].din);
      chk($sformatf("table_%0d", k), dut_out(0), tbl[k].exp);
    end

    // LSB-first order of 1011
    idle(8);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, (k == 0), 4'hB);
      chk($sformatf("lsb_bit%0d", k), {5'b0, if1.SOUT}, {5'b0, t2[k]});
    end
    cycle(1'b1, 1'b0, 4'h0);
    chk("lsb_done", {4'b0, if1.DONE, if1.LOAD_READY}, 6'b000011);

    // Clear in the middle of a 1111 frame, then a clean 1001 frame
    idle(8);
    cycle(1'b1, 1'b1, 4'hF);
    cycle(1'b1, 1'b0, 4'h0);
    clr_pulse();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b0, 4'h0);
      chk("clr_no_done", {5'b0, if0.DONE}, 6'b0);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, (k == 0), 4'h9);
      chk($sformatf("after_clr_bit%0d", k), {5'b0, if0.SOUT}, {5'b0, t4[k]});
    end

    // Back-to-back frames with a gap
    idle(8);
    for (int k = 0; k < 11; k++) begin
      cycle(1'b1, 1'b1, (k == 0) ? 4'hA : 4'h5);
      chk($sformatf("gap_step%0d", k + 1), dut_out(2), t5[k]);
    end
    lv = 1'b0;

    // LOAD_VALID pulse while shifting is ignored
    idle(8);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, (k == 0) || (k == 1), (k == 0) ? 4'h5 : 4'hF);
      chk($sformatf("ignore_step%0d", k + 1), dut_out(0), t6[k]);
    end

    // Randomized traffic against the model, with occasional clears
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)));
      if ($urandom_range(0, 63) == 0) clr_pulse();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
